// File: rtl/next_pc_unit.sv
// Next-PC and exception sequencing for the stage feeding the PC register.
// Selects the next fetch address, raises traps to the fixed vector by
// dropping pc_en, and tracks EPC/cause with a two-state trap FSM.
module next_pc_unit #(
  parameter logic [15:0] VEC_ADDR    = 16'h0000,
  parameter int          INSTR_BYTES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [15:0] branch_off,
  input  logic [11:0] jump_imm,
  input  logic [15:0] jr_addr,
  input  logic        eret,
  input  logic        illegal_op,
  input  logic        ovf,
  output logic [15:0] pc_next,
  output logic        pc_en,
  output logic [15:0] epc,
  output logic [1:0]  cause,
  output logic        in_handler,
  output logic        double_fault
);

  typedef enum logic {RUN, HANDLER} state_t;

  localparam logic [15:0] StepBytes = 16'(INSTR_BYTES);

  localparam logic [1:0] CauseNone     = 2'b00;
  localparam logic [1:0] CauseIllegal  = 2'b01;
  localparam logic [1:0] CauseOverflow = 2'b10;
  localparam logic [1:0] CauseMisalign = 2'b11;

  state_t      state_q;
  logic [15:0] epc_q;
  logic [1:0]  cause_q;
  logic        inHandler_q;
  logic        doubleFault_q;

  logic [15:0] pcPlus;
  logic [15:0] branchTarget;
  logic [15:0] jumpTarget;
  logic [15:0] selTarget;
  logic        misaligned;
  logic        runIllegal;
  logic        runExc;
  logic [1:0]  cause_d;
  logic        handlerEvent;

  // The vector is hardwired in the PC register; kept here only as a record.
  logic unusedVecAddr;
  assign unusedVecAddr = ^VEC_ADDR;

  // Candidate targets; all sums wrap at 16 bits.
  always_comb begin
    pcPlus       = pc + StepBytes;
    branchTarget = pcPlus + (branch_off << 1);
    jumpTarget   = {pcPlus[15:13], jump_imm, 1'b0};
  end

  // Pick the target from pc_src; an untaken branch falls through.
  always_comb begin
    selTarget = pcPlus;
    unique case (pc_src)
      2'b00: selTarget = pcPlus;
      2'b01: selTarget = branch_taken ? branchTarget : pcPlus;
      2'b10: selTarget = jumpTarget;
      2'b11: selTarget = jr_addr;
      default: selTarget = pcPlus;
    endcase
  end

  // Classify exceptional conditions; eret outside a handler is illegal.
  always_comb begin
    misaligned   = selTarget[0];
    runIllegal   = illegal_op | eret;
    runExc       = runIllegal | ovf | misaligned;
    handlerEvent = illegal_op | ovf | misaligned;
    cause_d      = CauseNone;
    if (runIllegal)      cause_d = CauseIllegal;
    else if (ovf)        cause_d = CauseOverflow;
    else if (misaligned) cause_d = CauseMisalign;
  end

  // Same-cycle PC steering: trap drops pc_en, eret in the handler returns past EPC.
  always_comb begin
    pc_next = selTarget;
    pc_en   = 1'b1;
    if (state_q == RUN) begin
      if (runExc) pc_en = 1'b0;
    end else begin
      if (eret) pc_next = epc_q + StepBytes;
    end
    if (!rst) pc_en = 1'b1;
  end

  // Trap FSM with EPC, cause, handler flag and sticky double-fault registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      epc_q         <= 16'h0000;
      cause_q       <= CauseNone;
      inHandler_q   <= 1'b0;
      doubleFault_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (runExc) begin
            epc_q       <= pc;
            cause_q     <= cause_d;
            state_q     <= HANDLER;
            inHandler_q <= 1'b1;
          end
        end
        HANDLER: begin
          if (handlerEvent) doubleFault_q <= 1'b1;
          if (eret) begin
            cause_q     <= CauseNone;
            state_q     <= RUN;
            inHandler_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= RUN;
          inHandler_q <= 1'b0;
        end
      endcase
    end
  end

  assign epc          = epc_q;
  assign cause        = cause_q;
  assign in_handler   = inHandler_q;
  assign double_fault = doubleFault_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed walk through the trap
// scenarios followed by randomized cycles, against a behavioural model.
module tb_next_pc_unit;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [15:0] branch_off;
  logic [11:0] jump_imm;
  logic [15:0] jr_addr;
  logic        eret;
  logic        illegal_op;
  logic        ovf;
  logic [15:0] pc_next;
  logic        pc_en;
  logic [15:0] epc;
  logic [1:0]  cause;
  logic        in_handler;
  logic        double_fault;

  int passed;
  int total;

  // Behavioural model state
  bit          mInHandler;
  bit [15:0]   mEpc;
  bit [1:0]    mCause;
  bit          mDoubleFault;

  logic [15:0] obsNext;
  logic        obsEn;

  next_pc_unit dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_src(pc_src),
    .branch_taken(branch_taken), .branch_off(branch_off),
    .jump_imm(jump_imm), .jr_addr(jr_addr), .eret(eret),
    .illegal_op(illegal_op), .ovf(ovf), .pc_next(pc_next),
    .pc_en(pc_en), .epc(epc), .cause(cause),
    .in_handler(in_handler), .double_fault(double_fault)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Target address per the instruction semantics, using plain integer math.
  function automatic int modelTarget(input int p, input int src, input bit tk,
                                     input int off, input int jimm, input int jr);
    int plus;
    int soff;
    plus = (p + 2) % 65536;
    soff = (off >= 32768) ? off - 65536 : off;
    case (src)
      1:       return tk ? (plus + 2 * soff + 4 * 65536) % 65536 : plus;
      2:       return (plus / 8192) * 8192 + jimm * 2;
      3:       return jr;
      default: return plus;
    endcase
  endfunction

  // One clock: drive at negedge, check combinational outputs, then registers after the edge.
  task automatic applyStimulus(input bit r, input logic [15:0] p, input logic [1:0] src,
                               input bit tk, input logic [15:0] off, input logic [11:0] jimm,
                               input logic [15:0] jr, input bit er, input bit ill, input bit ov);
    int tgt;
    bit mis;
    bit exc;
    int expNext;
    bit expEn;
    @(negedge clk);
    rst = r; pc = p; pc_src = src; branch_taken = tk; branch_off = off;
    jump_imm = jimm; jr_addr = jr; eret = er; illegal_op = ill; ovf = ov;
    #1;
    tgt = modelTarget(int'(p), int'(src), tk, int'(off), int'(jimm), int'(jr));
    mis = (tgt % 2) == 1;
    exc = !mInHandler && (ill || er || ov || mis);
    expNext = (mInHandler && er) ? (int'(mEpc) + 2) % 65536 : tgt;
    expEn = !r ? 1'b1 : !exc;
    obsNext = pc_next;
    obsEn = pc_en;
    checkOutput("pc_next", pc_next, 16'(expNext));
    checkOutput("pc_en", {15'd0, pc_en}, {15'd0, expEn});
    @(posedge clk);
    if (!r) begin
      mInHandler = 0; mEpc = 0; mCause = 0; mDoubleFault = 0;
    end else if (!mInHandler) begin
      if (exc) begin
        mEpc = p;
        mCause = (ill || er) ? 2'd1 : ov ? 2'd2 : 2'd3;
        mInHandler = 1;
      end
    end else begin
      if (ill || ov || mis) mDoubleFault = 1;
      if (er) begin
        mCause = 0;
        mInHandler = 0;
      end
    end
    #1;
    checkOutput("epc", epc, mEpc);
    checkOutput("cause", {14'd0, cause}, {14'd0, mCause});
    checkOutput("in_handler", {15'd0, in_handler}, {15'd0, mInHandler});
    checkOutput("double_fault", {15'd0, double_fault}, {15'd0, mDoubleFault});
  endtask

  initial begin
    passed = 0;
    total = 0;
    mInHandler = 0; mEpc = 0; mCause = 0; mDoubleFault = 0;
    rst = 0; pc = 0; pc_src = 0; branch_taken = 0; branch_off = 0;
    jump_imm = 0; jr_addr = 0; eret = 0; illegal_op = 0; ovf = 0;

    // Reset for two cycles, then sequential fetch
    applyStimulus(0, 16'h0000, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 0, 0, 0);
    applyStimulus(0, 16'h0000, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 0, 0, 0);
    applyStimulus(1, 16'h0010, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 0, 0, 0);
    checkOutput("tp_seq_next", obsNext, 16'h0012);
    checkOutput("tp_seq_cause", {14'd0, cause}, 16'h0000);

    // Branch backwards and jump
    applyStimulus(1, 16'h0100, 2'b01, 1, 16'hFFFE, 12'h000, 16'h0000, 0, 0, 0);
    checkOutput("tp_branch", obsNext, 16'h00FE);
    applyStimulus(1, 16'h2100, 2'b10, 0, 16'h0000, 12'h123, 16'h0000, 0, 0, 0);
    checkOutput("tp_jump", obsNext, 16'h2246);

    // Overflow trap, one handler instruction, then return past the fault
    applyStimulus(1, 16'h0040, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 0, 0, 1);
    checkOutput("tp_ovf_en", {15'd0, obsEn}, 16'h0000);
    checkOutput("tp_ovf_epc", epc, 16'h0040);
    checkOutput("tp_ovf_cause", {14'd0, cause}, 16'h0002);
    applyStimulus(1, 16'h0000, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 0, 0, 0);
    applyStimulus(1, 16'h0002, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 1, 0, 0);
    checkOutput("tp_eret_next", obsNext, 16'h0042);
    checkOutput("tp_eret_inh", {15'd0, in_handler}, 16'h0000);

    // Illegal beats overflow; then return
    applyStimulus(1, 16'h0080, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 0, 1, 1);
    checkOutput("tp_prio_cause", {14'd0, cause}, 16'h0001);
    applyStimulus(1, 16'h0000, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 1, 0, 0);

    // Misaligned register jump traps
    applyStimulus(1, 16'h0090, 2'b11, 0, 16'h0000, 12'h000, 16'h0301, 0, 0, 0);
    checkOutput("tp_mis_en", {15'd0, obsEn}, 16'h0000);
    checkOutput("tp_mis_cause", {14'd0, cause}, 16'h0003);
    checkOutput("tp_mis_epc", epc, 16'h0090);

    // Overflow inside the handler only marks a double fault
    applyStimulus(1, 16'h0000, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 0, 0, 1);
    checkOutput("tp_df_en", {15'd0, obsEn}, 16'h0001);
    checkOutput("tp_df_flag", {15'd0, double_fault}, 16'h0001);
    checkOutput("tp_df_epc", epc, 16'h0090);
    applyStimulus(1, 16'h0002, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 1, 0, 0);

    // eret while running is an illegal instruction
    applyStimulus(1, 16'h0200, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 1, 0, 0);
    checkOutput("tp_eretrun_cause", {14'd0, cause}, 16'h0001);
    checkOutput("tp_eretrun_epc", epc, 16'h0200);

    // Reset abandons the handler, then sequential wrap at the top of memory
    applyStimulus(0, 16'h0000, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 0, 0, 0);
    checkOutput("tp_rst_inh", {15'd0, in_handler}, 16'h0000);
    checkOutput("tp_rst_df", {15'd0, double_fault}, 16'h0000);
    applyStimulus(1, 16'hFFFE, 2'b00, 0, 16'h0000, 12'h000, 16'h0000, 0, 0, 0);
    checkOutput("tp_wrap_next", obsNext, 16'h0000);
    checkOutput("tp_wrap_en", {15'd0, obsEn}, 16'h0001);

    // Branch target wrapping past 0xFFFF
    applyStimulus(1, 16'hFFF0, 2'b01, 1, 16'h0010, 12'h000, 16'h0000, 0, 0, 0);
    checkOutput("tp_bwrap", obsNext, 16'h0012);

    // Randomized cycles against the model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] rjr;
      rjr = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rjr[0] = 1'b0;
      applyStimulus($urandom_range(0, 63) != 0, 16'($urandom) & 16'hFFFE,
                    2'($urandom), 1'($urandom), 16'($urandom), 12'($urandom), rjr,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
